// File: rtl/rf_param.sv
// rf_param: parametrised register file (2 registered read ports, 1 write port) with a per-register pending-write scoreboard.
// Compile-time macro RF_BYPASS_EN selects write-to-read forwarding; without it, same-edge reads return the pre-write contents.
module rf_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              regwr,
   input  logic [ADDR_W-1:0] wr,
   input  logic [DATA_W-1:0] wd,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rr1,
   input  logic [ADDR_W-1:0] rr2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_addr,
   output logic              busy1,
   output logic              busy2
);

   localparam int DEPTH = 2**ADDR_W;
   localparam bit ZR_EN = (ZERO_REG != 32'sd0);

   logic [DATA_W-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0]  pend_r;

   logic              wr_ok_s;
   logic [DEPTH-1:0]  clr_mask_s;
   logic [DEPTH-1:0]  set_mask_s;
   logic [DEPTH-1:0]  pend_cleared_s;
   logic [DEPTH-1:0]  pend_next_s;
   logic [DATA_W-1:0] rd1_next_s;
   logic [DATA_W-1:0] rd2_next_s;
   logic              busy1_next_s;
   logic              busy2_next_s;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZR_EN && (a == {ADDR_W{1'b0}});
   endfunction

   // Write qualification: register 0 is read-only when hardwired to zero.
   always_comb begin
      wr_ok_s = 1'b0;
      if (regwr && !is_zero(wr)) begin
         wr_ok_s = 1'b1;
      end else begin
         wr_ok_s = 1'b0;
      end
   end

   // Scoreboard next state: writeback clears, issue sets, and set wins on a same-address collision.
   always_comb begin
      clr_mask_s = {DEPTH{1'b0}};
      set_mask_s = {DEPTH{1'b0}};
      if (regwr) begin
         clr_mask_s[wr] = 1'b1;
      end else begin
         clr_mask_s = {DEPTH{1'b0}};
      end
      if (sb_set && !is_zero(sb_addr)) begin
         set_mask_s[sb_addr] = 1'b1;
      end else begin
         set_mask_s = {DEPTH{1'b0}};
      end
      pend_cleared_s = pend_r & ~clr_mask_s;
      pend_next_s    = pend_cleared_s | set_mask_s;
   end

   // Read port 1 next value; the zero-register rule outranks forwarding.
   always_comb begin
      rd1_next_s   = {DATA_W{1'b0}};
      busy1_next_s = 1'b0;
      if (is_zero(rr1)) begin
         rd1_next_s = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
      end else if (wr_ok_s && (wr == rr1)) begin
         rd1_next_s = wd;
`endif
      end else begin
         rd1_next_s = regs_r[rr1];
      end
      // Busy reflects this edge's writeback but not this edge's issue.
      if (is_zero(rr1)) begin
         busy1_next_s = 1'b0;
      end else begin
         busy1_next_s = pend_cleared_s[rr1];
      end
   end

   // Read port 2 next value; mirrors port 1.
   always_comb begin
      rd2_next_s   = {DATA_W{1'b0}};
      busy2_next_s = 1'b0;
      if (is_zero(rr2)) begin
         rd2_next_s = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
      end else if (wr_ok_s && (wr == rr2)) begin
         rd2_next_s = wd;
`endif
      end else begin
         rd2_next_s = regs_r[rr2];
      end
      if (is_zero(rr2)) begin
         busy2_next_s = 1'b0;
      end else begin
         busy2_next_s = pend_cleared_s[rr2];
      end
   end

   // Register array storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_ok_s) begin
         regs_r[wr] <= wd;
      end
   end

   // Pending-write scoreboard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r <= {DEPTH{1'b0}};
      end else begin
         pend_r <= pend_next_s;
      end
   end

   // Registered read data and busy flags, held while rd_en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd1   <= {DATA_W{1'b0}};
         rd2   <= {DATA_W{1'b0}};
         busy1 <= 1'b0;
         busy2 <= 1'b0;
      end else if (rd_en) begin
         rd1   <= rd1_next_s;
         rd2   <= rd2_next_s;
         busy1 <= busy1_next_s;
         busy2 <= busy2_next_s;
      end
   end

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: directed plus randomized self-checking bench for rf_param against an array-based reference model.
// Honours RF_BYPASS_EN the same way as the design build.
module tb_rf_param;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;
   localparam bit ZR = 1'b1;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          regwr   = 1'b0;
   logic [AW-1:0] wr      = '0;
   logic [DW-1:0] wd      = '0;
   logic          rd_en   = 1'b0;
   logic [AW-1:0] rr1     = '0;
   logic [AW-1:0] rr2     = '0;
   logic          sb_set  = 1'b0;
   logic [AW-1:0] sb_addr = '0;
   logic [DW-1:0] rd1, rd2;
   logic          busy1, busy2;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic [DW-1:0] m_reg [NR];
   bit            m_pend [NR];
   logic [DW-1:0] e_rd1 = '0;
   logic [DW-1:0] e_rd2 = '0;
   bit            e_b1  = 1'b0;
   bit            e_b2  = 1'b0;

   always #5 clk = ~clk;

   rf_param dut (
      .clk(clk), .rst(rst), .regwr(regwr), .wr(wr), .wd(wd),
      .rd_en(rd_en), .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy1(busy1), .busy2(busy2)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value a read of address a sees at the current edge.
   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
      if (ZR && a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (regwr && wr == a) return wd;
`endif
      return m_reg[a];
   endfunction

   // Pending state after this edge's writeback, before this edge's issue.
   function automatic bit m_busy(input logic [AW-1:0] a);
      if (ZR && a == 0) return 1'b0;
      if (regwr && wr == a) return 1'b0;
      return m_pend[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
         end
         e_rd1 = '0; e_rd2 = '0; e_b1 = 1'b0; e_b2 = 1'b0;
      end else begin
         if (rd_en) begin
            e_rd1 = m_read(rr1); e_rd2 = m_read(rr2);
            e_b1  = m_busy(rr1); e_b2  = m_busy(rr2);
         end
         if (regwr) begin
            if (!(ZR && wr == 0)) m_reg[wr] = wd;
            m_pend[wr] = 1'b0;
         end
         if (sb_set && !(ZR && sb_addr == 0)) m_pend[sb_addr] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_rd1", rd1, e_rd1);
         check("model_rd2", rd2, e_rd2);
         check("model_busy1", {31'd0, busy1}, {31'd0, e_b1});
         check("model_busy2", {31'd0, busy2}, {31'd0, e_b2});
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      regwr = 1'b0; sb_set = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         m_reg[i] = '0; m_pend[i] = 1'b0;
      end
      cyc(); cyc();
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset then read
      rr1 = 5'd3; rr2 = 5'd31; rd_en = 1'b1;
      cyc();
      check("rst_rd1", rd1, 32'h0);
      check("rst_rd2", rd2, 32'h0);
      check("rst_busy", {30'd0, busy1, busy2}, 32'h0);

      // Write then read, then hold
      idle(); regwr = 1'b1; wr = 5'd2; wd = 32'h0123;
      cyc();
      idle(); rr1 = 5'd2; rd_en = 1'b1;
      cyc();
      check("wr_rd1", rd1, 32'h0123);
      rd_en = 1'b0; rr1 = 5'd9;
      cyc();
      check("hold_rd1", rd1, 32'h0123);

      // Same-cycle RAW on reg5
      idle(); regwr = 1'b1; wr = 5'd5; wd = 32'h11;
      cyc();
      regwr = 1'b1; wr = 5'd5; wd = 32'hDEAD_BEEF; rr1 = 5'd5; rd_en = 1'b1;
      cyc();
`ifdef RF_BYPASS_EN
      check("raw_rd1", rd1, 32'hDEAD_BEEF);
`else
      check("raw_rd1", rd1, 32'h11);
`endif
      idle(); rd_en = 1'b1;
      cyc();
      check("raw_next_rd1", rd1, 32'hDEAD_BEEF);

      // Zero register
      idle(); regwr = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF; sb_set = 1'b1; sb_addr = 5'd0;
      rr1 = 5'd0; rd_en = 1'b1;
      cyc();
      idle(); rr1 = 5'd0; rd_en = 1'b1;
      cyc();
      check("zero_rd1", rd1, 32'h0);
      check("zero_busy1", {31'd0, busy1}, 32'h0);

      // Scoreboard
      idle(); sb_set = 1'b1; sb_addr = 5'd7;
      cyc();
      idle(); rr2 = 5'd7; rd_en = 1'b1;
      cyc();
      check("sb_busy2_set", {31'd0, busy2}, 32'h1);
      idle(); regwr = 1'b1; wr = 5'd7; wd = 32'h77; rr2 = 5'd7; rd_en = 1'b1;
      cyc();
      check("sb_busy2_wb", {31'd0, busy2}, 32'h0);
      idle(); regwr = 1'b1; wr = 5'd7; wd = 32'h78; sb_set = 1'b1; sb_addr = 5'd7;
      cyc();
      idle(); rr2 = 5'd7; rd_en = 1'b1;
      cyc();
      check("sb_busy2_both", {31'd0, busy2}, 32'h1);
      check("sb_rd2_both", rd2, 32'h78);

      // Async reset mid-operation
      for (int i = 1; i <= 4; i++) begin
         idle(); regwr = 1'b1; wr = AW'(i); wd = 32'hA000 + i;
         sb_set = (i == 4); sb_addr = 5'd4;
         cyc();
      end
      idle(); rr1 = 5'd4; rr2 = 5'd3; rd_en = 1'b1;
      cyc();
      check("pre_rst_rd1", rd1, 32'hA004);
      check("pre_rst_busy1", {31'd0, busy1}, 32'h1);
      idle(); regwr = 1'b1; wr = 5'd3; wd = 32'hBAD0;
      rst = 1'b1;
      #1;
      check("async_rd1", rd1, 32'h0);
      check("async_rd2", rd2, 32'h0);
      check("async_busy1", {31'd0, busy1}, 32'h0);
      cyc();
      rst = 1'b0; idle();
      rr1 = 5'd3; rr2 = 5'd4; rd_en = 1'b1;
      cyc();
      check("post_rst_rd1", rd1, 32'h0);
      check("post_rst_rd2", rd2, 32'h0);
      check("post_rst_busy", {30'd0, busy1, busy2}, 32'h0);
      rr1 = 5'd1; rr2 = 5'd2;
      cyc();
      check("post_rst_rd12", rd1 | rd2, 32'h0);

      // Randomized traffic, addresses biased low to force collisions
      for (int n = 0; n < 2000; n++) begin
         regwr   = ($urandom_range(0, 2) != 0);
         sb_set  = ($urandom_range(0, 2) == 0);
         rd_en   = ($urandom_range(0, 3) != 0);
         wd      = $urandom;
         wr      = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         rr1     = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         rr2     = ($urandom_range(0, 3) == 0) ? rr1 : AW'($urandom_range(0, 7));
         sb_addr = ($urandom_range(0, 1) != 0) ? wr : AW'($urandom_range(0, 7));
         cyc();
      end

      idle();
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised register file for the CPU datapath: generalised width and depth, two read ports, one write port.
- Read data is registered, and reads are decoupled from writes, so both can happen in the same cycle.
- Optional r0-hardwired-zero behaviour.
- Adds a per-register pending-write scoreboard so the control unit can detect load-use and other RAW hazards before writeback.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never marked pending.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- regwr  input  1  write enable.
- wr  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- rd_en  input  1  read enable; when 0, rd1/rd2/busy1/busy2 hold their values.
- rr1  input  ADDR_W  read address, port 1.
- rr2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  registered read data, port 1.
- rd2  output  DATA_W  registered read data, port 2.
- sb_set  input  1  mark register sb_addr as pending (issued producer).
- sb_addr  input  ADDR_W  scoreboard set address.
- busy1  output  1  registered pending flag of rr1.
- busy2  output  1  registered pending flag of rr2.

Behaviour:
- Reset (async, rst=1):
  - all 2**ADDR_W registers = 0.
  - all pending bits = 0.
  - rd1 = rd2 = 0, busy1 = busy2 = 0.
  - Takes effect immediately, mid-cycle included; a write in flight during reset is discarded.
- Write: at posedge, if regwr=1, reg[wr] <= wd. If ZERO_REG=1 and wr=0, the write is dropped.
- Read latency:
  - 1 cycle: if rd_en=1 at posedge N, rd1/rd2 show the value for rr1/rr2 sampled at edge N, valid after edge N.
  - If rd_en=0, outputs hold.
- Same-address read/write in one cycle:
  - Behaviour is set by RF_BYPASS_EN (see Optional Feature).
  - The written register always holds wd afterwards.
- Register 0 with ZERO_REG=1: rd1/rd2 = 0 and busy = 0 for address 0, regardless of writes or sb_set.
- Scoreboard, one pending bit per register:
  - sb_set=1 sets pending[sb_addr].
  - regwr=1 clears pending[wr].
  - Same edge, same address, both set and clear: set wins (newer producer issued).
  - Same edge, different addresses: both apply.
- busy1/busy2:
  - Sampled on rd_en like the data: busy1 <= pending[rr1] as it stands after this edge's clear and before this edge's set.
  - A same-cycle writeback therefore reports not busy.
  - A same-cycle sb_set to rr is not yet visible.
- rr1 = rr2 is legal; both ports return identical data and busy.
- Address width fully decoded; no out-of-range addresses exist.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding. If regwr=1 and wr = rr1 (or rr2) at the same edge with rd_en=1, rd1 (rd2) <= wd. Zero-register rule still takes precedence.
- Not defined: reads return the pre-write contents (read-before-write). The new value is visible on the next read.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- Reset then read: rst pulse; rr1=3, rr2=31, rd_en=1 -> rd1=0, rd2=0, busy1=busy2=0 after next edge.
- Write/read: regwr=1, wr=2, wd=32'h0123; next cycle rr1=2, rd_en=1 -> rd1=32'h0123 one edge later; rd_en=0 afterwards holds 32'h0123 while rr1 changes.
- Same-cycle RAW: wr=5, wd=32'hDEAD_BEEF, rr1=5 (reg5 previously 32'h11) -> rd1=32'hDEADBEEF with RF_BYPASS_EN; rd1=32'h11 without it.
- Zero register (ZERO_REG=1): write wr=0, wd=32'hFFFF_FFFF, sb_set with sb_addr=0 -> reading rr1=0 gives rd1=0, busy1=0.
- Scoreboard:
  - sb_set, sb_addr=7; next cycle rr2=7 -> busy2=1.
  - Writeback regwr, wr=7 with rr2=7 read same edge -> busy2=0.
  - Simultaneous sb_set=7 and regwr wr=7, then read rr2=7 -> busy2=1.
- Async reset mid-operation: regs 1..4 written, pending[4]=1, rst asserted between edges -> rd1/rd2/busy cleared immediately; subsequent reads of 1..4 return 0 and not busy.
